// File: rtl/daq_master_arb.sv
// Round-robin arbiter/sequencer sharing the DAQ Wishbone master command port between the
// host command port (0) and the DAQ state machine (1). All outputs are registered.
module daq_master_arb #(
    parameter int unsigned aw          = 32,
    parameter int unsigned dw          = 32,
    parameter int unsigned ACT_TIMEOUT = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          r0_req_i,
    input  logic [aw-1:0] r0_address_i,
    input  logic [3:0]    r0_selection_i,
    input  logic          r0_write_i,
    input  logic [dw-1:0] r0_data_wr_i,
    output logic          r0_gnt_o,
    output logic          r0_done_o,
    output logic          r0_timeout_o,
    output logic [dw-1:0] r0_data_rd_o,
    input  logic          r1_req_i,
    input  logic [aw-1:0] r1_address_i,
    input  logic [3:0]    r1_selection_i,
    input  logic          r1_write_i,
    input  logic [dw-1:0] r1_data_wr_i,
    output logic          r1_gnt_o,
    output logic          r1_done_o,
    output logic          r1_timeout_o,
    output logic [dw-1:0] r1_data_rd_o,
    output logic          m_start_o,
    output logic [aw-1:0] m_address_o,
    output logic [3:0]    m_selection_o,
    output logic          m_write_o,
    output logic [dw-1:0] m_data_wr_o,
    input  logic [dw-1:0] m_data_rd_i,
    input  logic          m_active_i
);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitAct, StBusy, StDone} state_e;

    localparam logic [16:0] ToLimit = 17'(ACT_TIMEOUT);

    state_e        state_q;
    logic          last_q;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic [1:0]    to_q;
    logic [15:0]   cnt_q;
    logic          start_q;
    logic [aw-1:0] addr_q;
    logic [3:0]    sel_q;
    logic          write_q;
    logic [dw-1:0] wdata_q;
    logic [dw-1:0] rd0_q;
    logic [dw-1:0] rd1_q;
    logic          win;
    logic          to_hit;

    // With both requesting, the port that did not win last time goes next.
    always_comb begin
        win = r1_req_i;
        if (r0_req_i && r1_req_i) begin
            win = ~last_q;
        end
    end

    // Timeout fires on the WAIT_ACT cycle in which the counter would reach ACT_TIMEOUT-1.
    assign to_hit = ({1'b0, cnt_q} + 17'd2) >= ToLimit;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            done_q  <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (r0_req_i || r1_req_i) begin
                        state_q <= StIssue;
                        last_q  <= win;
                        gnt_q   <= win ? 2'b10 : 2'b01;
                        start_q <= 1'b1;
                        addr_q  <= win ? r1_address_i : r0_address_i;
                        sel_q   <= win ? r1_selection_i : r0_selection_i;
                        write_q <= win ? r1_write_i : r0_write_i;
                        wdata_q <= win ? r1_data_wr_i : r0_data_wr_i;
                    end
                end
                StIssue: begin
                    state_q <= StWaitAct;
                    cnt_q   <= '0;
                end
                StWaitAct: begin
                    if (m_active_i) begin
                        state_q <= StBusy;
                    end else if (to_hit) begin
                        state_q <= StDone;
                        done_q  <= gnt_q;
                        to_q    <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StBusy: begin
                    if (!m_active_i) begin
                        state_q <= StDone;
                        done_q  <= gnt_q;
                        if (!write_q && gnt_q[0]) rd0_q <= m_data_rd_i;
                        if (!write_q && gnt_q[1]) rd1_q <= m_data_rd_i;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    to_q    <= '0;
                    addr_q  <= '0;
                    sel_q   <= '0;
                    write_q <= 1'b0;
                    wdata_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign r0_gnt_o      = gnt_q[0];
    assign r1_gnt_o      = gnt_q[1];
    assign r0_done_o     = done_q[0];
    assign r1_done_o     = done_q[1];
    assign r0_timeout_o  = to_q[0];
    assign r1_timeout_o  = to_q[1];
    assign r0_data_rd_o  = rd0_q;
    assign r1_data_rd_o  = rd1_q;
    assign m_start_o     = start_q;
    assign m_address_o   = addr_q;
    assign m_selection_o = sel_q;
    assign m_write_o     = write_q;
    assign m_data_wr_o   = wdata_q;

endmodule

// File: tb/tb_daq_master_arb.sv
// Directed bench for daq_master_arb: single reads/writes, round-robin order, activity
// timeout, reset mid-transaction and idle quiescence.
module tb_daq_master_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r1_req, r0_write, r1_write, m_active;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata, m_data_rd;
    logic [3:0]  r0_sel, r1_sel;
    logic        r0_gnt, r1_gnt, r0_done, r1_done, r0_to, r1_to;
    logic [31:0] r0_rd, r1_rd;
    logic        m_start, m_write;
    logic [31:0] m_address, m_data_wr;
    logic [3:0]  m_selection;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rd [2];

    daq_master_arb #(.aw(32), .dw(32), .ACT_TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .r0_req_i(r0_req), .r0_address_i(r0_addr), .r0_selection_i(r0_sel),
        .r0_write_i(r0_write), .r0_data_wr_i(r0_wdata),
        .r0_gnt_o(r0_gnt), .r0_done_o(r0_done), .r0_timeout_o(r0_to), .r0_data_rd_o(r0_rd),
        .r1_req_i(r1_req), .r1_address_i(r1_addr), .r1_selection_i(r1_sel),
        .r1_write_i(r1_write), .r1_data_wr_i(r1_wdata),
        .r1_gnt_o(r1_gnt), .r1_done_o(r1_done), .r1_timeout_o(r1_to), .r1_data_rd_o(r1_rd),
        .m_start_o(m_start), .m_address_o(m_address), .m_selection_o(m_selection),
        .m_write_o(m_write), .m_data_wr_o(m_data_wr),
        .m_data_rd_i(m_data_rd), .m_active_i(m_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " start"}, 64'(m_start), 64'd0);
        check({tag, " gnt"}, 64'({r1_gnt, r0_gnt}), 64'd0);
        check({tag, " done"}, 64'({r1_done, r0_done}), 64'd0);
        check({tag, " timeout"}, 64'({r1_to, r0_to}), 64'd0);
        check({tag, " m_cmd"}, {m_address, m_data_wr}, 64'd0);
        check({tag, " m_selwr"}, 64'({m_selection, m_write}), 64'd0);
        check({tag, " rd0"}, 64'(r0_rd), 64'(exp_rd[0]));
        check({tag, " rd1"}, 64'(r1_rd), 64'(exp_rd[1]));
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] addr, input logic [3:0] sel,
                             input logic wr, input logic [31:0] wdata);
        check({tag, " m_address"}, 64'(m_address), 64'(addr));
        check({tag, " m_sel_wr"}, 64'({m_selection, m_write}), 64'({sel, wr}));
        check({tag, " m_data_wr"}, 64'(m_data_wr), 64'(wdata));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {r0_req, r1_req, r0_write, r1_write, m_active} = '0;
        {r0_addr, r1_addr, r0_wdata, r1_wdata, m_data_rd} = '0;
        r0_sel = '0;
        r1_sel = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Entered in an IDLE cycle with port p's request and command already driven.
    task automatic serve(input int p, input logic [31:0] addr, input logic [3:0] sel,
                         input logic wr, input logic [31:0] wdata, input logic [31:0] rdata);
        logic [1:0] g;
        g = (p == 0) ? 2'b01 : 2'b10;
        tick();
        check("issue start", 64'(m_start), 64'd1);
        check("issue gnt", 64'({r1_gnt, r0_gnt}), 64'(g));
        check_cmd("issue", addr, sel, wr, wdata);
        tick();
        check("wait start", 64'(m_start), 64'd0);
        check("wait gnt", 64'({r1_gnt, r0_gnt}), 64'(g));
        m_active = 1'b1;
        tick();
        check_cmd("busy", addr, sel, wr, wdata);
        tick();
        tick();
        m_active  = 1'b0;
        m_data_rd = rdata;
        check("busy done", 64'({r1_done, r0_done}), 64'd0);
        tick();
        if (!wr) exp_rd[p] = rdata;
        m_data_rd = 32'h0BAD_0BAD;
        check("done pulse", 64'({r1_done, r0_done}), 64'(g));
        check("done gnt", 64'({r1_gnt, r0_gnt}), 64'(g));
        check("done timeout", 64'({r1_to, r0_to}), 64'd0);
        check("done rd0", 64'(r0_rd), 64'(exp_rd[0]));
        check("done rd1", 64'(r1_rd), 64'(exp_rd[1]));
        check_cmd("done", addr, sel, wr, wdata);
        if (p == 0) r0_req = 1'b0;
        else        r1_req = 1'b0;
        tick();
        check_quiet("after done");
    endtask

    initial begin
        do_reset();
        check_quiet("reset");

        // Single port-0 read.
        r0_req = 1'b1; r0_addr = 32'h10; r0_sel = 4'hF; r0_write = 1'b0;
        serve(0, 32'h10, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF);

        // Simultaneous requests after reset: 0 first, then alternation.
        do_reset();
        r0_req = 1'b1; r0_addr = 32'h100; r0_sel = 4'h3;
        r1_req = 1'b1; r1_addr = 32'h200; r1_sel = 4'hC;
        serve(0, 32'h100, 4'h3, 1'b0, 32'h0, 32'h1111_0000);
        r0_req = 1'b1; r0_addr = 32'h104;
        serve(1, 32'h200, 4'hC, 1'b0, 32'h0, 32'h2222_0000);
        serve(0, 32'h104, 4'h3, 1'b0, 32'h0, 32'h3333_0000);

        // Port-1 write leaves its read data unchanged.
        r1_req = 1'b1; r1_addr = 32'h40; r1_sel = 4'hF; r1_write = 1'b1;
        r1_wdata = 32'hA5A5_0001;
        serve(1, 32'h40, 4'hF, 1'b1, 32'hA5A5_0001, 32'h7777_7777);
        r1_write = 1'b0;
        r1_wdata = '0;

        // Master never goes active: timeout four cycles after ISSUE.
        r0_req = 1'b1; r0_addr = 32'h80; r0_sel = 4'h1;
        tick();
        check("to issue start", 64'(m_start), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("to early done", 64'({r1_done, r0_done, r1_to, r0_to}), 64'd0);
        end
        tick();
        check("to done", 64'({r1_done, r0_done}), 64'b01);
        check("to flag", 64'({r1_to, r0_to}), 64'b01);
        check("to start", 64'(m_start), 64'd0);
        check("to rd0", 64'(r0_rd), 64'(exp_rd[0]));
        r0_req = 1'b0;
        tick();
        check_quiet("after timeout");
        r0_req = 1'b1; r0_addr = 32'h84;
        serve(0, 32'h84, 4'h1, 1'b0, 32'h0, 32'hCAFE_F00D);

        // Reset during BUSY.
        r1_req = 1'b1; r1_addr = 32'h300; r1_sel = 4'hF;
        tick();
        tick();
        m_active = 1'b1;
        tick();
        check("busy gnt before rst", 64'(r1_gnt), 64'd1);
        rst_n = 1'b0;
        #1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        check_quiet("async reset");
        r1_req   = 1'b0;
        m_active = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_quiet("post reset idle");
        r1_req = 1'b1;
        serve(1, 32'h300, 4'hF, 1'b0, 32'h0, 32'h5A5A_5A5A);

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_quiet("idle");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
